// File: rtl/stopwatch_pkg.sv
// Shared types and default rates for the stopwatch run-control and digit chain.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } sw_state_t;

  localparam int unsigned CLK_HZ_DEF    = 27_000_000;
  localparam int unsigned TICK_HZ_DEF   = 100;
  localparam int unsigned DB_CYCLES_DEF = 270_000;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stable-level debounce, rising-edge press pulse.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic clk,
  input  logic nrst,
  input  logic btn,
  output logic press
);

  localparam int unsigned CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Any cycle where the synchronized input agrees with the level restarts the run.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (sync2 != level) begin
      if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) level_d <= 1'b0;
    else       level_d <= level;
  end

  assign press = level & ~level_d;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run-control sequencer: button conditioning, IDLE/RUN/PAUSE/LAP FSM and count prescaler.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ    = CLK_HZ_DEF,
  parameter int unsigned TICK_HZ   = TICK_HZ_DEF,
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       btn_ss,
  input  logic       btn_lap,
  input  logic       btn_clr,
  input  logic       ovf,
  output logic       cnt_en,
  output logic       cnt_up,
  output logic       cnt_clr,
  output logic       lap_latch,
  output logic       disp_hold,
  output logic [1:0] state,
  output logic       ovf_flag
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  logic ss_p, lap_p, clr_p;
  logic p_ss, p_lap, p_clr;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ss  (.clk(clk), .nrst(nrst), .btn(btn_ss),  .press(ss_p));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lap (.clk(clk), .nrst(nrst), .btn(btn_lap), .press(lap_p));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (.clk(clk), .nrst(nrst), .btn(btn_clr), .press(clr_p));

  sw_state_t     state_q, state_nx;
  logic [PW-1:0] presc;
  logic          counting;
  logic          clr_nx, latch_nx, hold_nx, flag_nx;

  assign p_clr    = clr_p;
  assign p_ss     = ss_p & ~clr_p;
  assign p_lap    = lap_p & ~clr_p & ~ss_p;

  assign counting = (state_q == ST_RUN) || (state_q == ST_LAP);
  assign cnt_en   = counting && (presc == PRESC_LAST);
  assign cnt_up   = counting;
  assign state    = state_q;

  // Partial periods survive PAUSE because the divider only advances while counting.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)              presc <= '0;
    else if (cnt_clr)       presc <= '0;
    else if (counting)      presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
  end

  always_comb begin
    state_nx = state_q;
    clr_nx   = 1'b0;
    latch_nx = 1'b0;
    hold_nx  = disp_hold;
    flag_nx  = ovf_flag;
    if (cnt_en && ovf) begin
      // Chain rolled over: stop and flag, regardless of any press this cycle.
      state_nx = ST_PAUSE;
      flag_nx  = 1'b1;
      hold_nx  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (p_clr) begin
            clr_nx  = 1'b1;
            flag_nx = 1'b0;
          end else if (p_ss) begin
            state_nx = ST_RUN;
          end
        end
        ST_RUN: begin
          if (p_ss) begin
            state_nx = ST_PAUSE;
          end else if (p_lap) begin
            state_nx = ST_LAP;
            latch_nx = 1'b1;
            hold_nx  = 1'b1;
          end
        end
        ST_LAP: begin
          if (p_ss) begin
            state_nx = ST_PAUSE;
            hold_nx  = 1'b0;
          end else if (p_lap) begin
            state_nx = ST_RUN;
            hold_nx  = 1'b0;
          end
        end
        ST_PAUSE: begin
          if (p_clr) begin
            state_nx = ST_IDLE;
            clr_nx   = 1'b1;
            flag_nx  = 1'b0;
          end else if (p_ss) begin
            state_nx = ST_RUN;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= ST_IDLE;
      cnt_clr   <= 1'b0;
      lap_latch <= 1'b0;
      disp_hold <= 1'b0;
      ovf_flag  <= 1'b0;
    end else begin
      state_q   <= state_nx;
      cnt_clr   <= clr_nx;
      lap_latch <= latch_nx;
      disp_hold <= hold_nx;
      ovf_flag  <= flag_nx;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl with DIV=10, DB_CYCLES=4.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       btn_ss = 1'b0;
  logic       btn_lap = 1'b0;
  logic       btn_clr = 1'b0;
  logic       ovf = 1'b0;
  logic       cnt_en, cnt_up, cnt_clr, lap_latch, disp_hold, ovf_flag;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  int latch_seen = 0;
  int clr_seen = 0;
  int viol = 0;

  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_LAP = 2'd3;

  stopwatch_ctrl #(.CLK_HZ(1000), .TICK_HZ(100), .DB_CYCLES(4)) dut (
    .clk(clk), .nrst(nrst), .btn_ss(btn_ss), .btn_lap(btn_lap), .btn_clr(btn_clr),
    .ovf(ovf), .cnt_en(cnt_en), .cnt_up(cnt_up), .cnt_clr(cnt_clr),
    .lap_latch(lap_latch), .disp_hold(disp_hold), .state(state), .ovf_flag(ovf_flag)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (nrst) begin
      if (lap_latch) latch_seen++;
      if (cnt_clr) clr_seen++;
      if (cnt_en && (state == S_IDLE || state == S_PAUSE || cnt_clr)) viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic drive(input logic [2:0] m);
    btn_ss  = m[0];
    btn_lap = m[1];
    btn_clr = m[2];
  endtask

  task automatic wait_state(input logic [1:0] s, output int n);
    n = 0;
    while (state !== s && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_en(output int n);
    n = 0;
    while (cnt_en !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_presc(input int v);
    int n = 0;
    while (int'(dut.presc) != v && n < 20) begin
      tick();
      n++;
    end
    check("presc_align", 32'(dut.presc), 32'(v));
  endtask

  task automatic go(input logic [2:0] m, input logic [1:0] s, input string tag);
    int n;
    drive(m);
    wait_state(s, n);
    check(tag, 32'(state), 32'(s));
    drive(3'b000);
    ticks(10);
  endtask

  initial begin
    int n;
    int base;
    int en_cnt;

    ticks(2);
    check("reset_outs", {24'd0, cnt_en, cnt_up, cnt_clr, lap_latch, disp_hold, ovf_flag, state}, 32'd0);
    nrst = 1'b1;
    ticks(2);

    // Start from IDLE: 2 sync + 4 debounce + 1 edge cycles to the state change.
    drive(3'b001);
    wait_state(S_RUN, n);
    check("ss_latency", 32'(n), 32'd7);
    check("run_cnt_up", 32'(cnt_up), 32'd1);
    wait_en(n);
    check("first_en", 32'(n), 32'd9);
    drive(3'b000);
    tick();
    wait_en(n);
    check("en_period", 32'(n + 1), 32'd10);
    ticks(8);

    // Bounce rejection on lap, then a clean hold.
    base = latch_seen;
    for (int i = 0; i < 5; i++) begin
      btn_lap = 1'b1;
      ticks(2);
      btn_lap = 1'b0;
      ticks(2);
    end
    check("bounce_state", 32'(state), 32'(S_RUN));
    check("bounce_latch", 32'(latch_seen - base), 32'd0);
    btn_lap = 1'b1;
    wait_state(S_LAP, n);
    check("lap_state", 32'(state), 32'(S_LAP));
    check("lap_latch_hi", 32'(lap_latch), 32'd1);
    check("lap_hold", 32'(disp_hold), 32'd1);
    check("lap_cnt_up", 32'(cnt_up), 32'd1);
    tick();
    check("lap_latch_lo", 32'(lap_latch), 32'd0);
    btn_lap = 1'b0;
    wait_en(n);
    check("lap_en_runs", 32'(cnt_en), 32'd1);
    ticks(10);
    check("lap_latch_once", 32'(latch_seen - base), 32'd1);

    go(3'b010, S_RUN, "lap_back_run");
    check("lap_back_hold", 32'(disp_hold), 32'd0);

    // Pause with press pulse landing at presc=6; resume from the held 7.
    wait_presc(0);
    drive(3'b001);
    ticks(6);
    check("pause_pulse_presc", 32'(dut.presc), 32'd6);
    tick();
    check("pause_state", 32'(state), 32'(S_PAUSE));
    check("pause_presc_hold", 32'(dut.presc), 32'd7);
    drive(3'b000);
    en_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (cnt_en) en_cnt++;
    end
    check("pause_silent", 32'(en_cnt), 32'd0);
    drive(3'b001);
    wait_state(S_RUN, n);
    check("resume_state", 32'(state), 32'(S_RUN));
    drive(3'b000);
    wait_en(n);
    check("resume_en", 32'(n), 32'd2);
    ticks(10);

    // ss and lap together in RUN: ss wins, lap discarded.
    base = latch_seen;
    go(3'b011, S_PAUSE, "simul_state");
    check("simul_no_latch", 32'(latch_seen - base), 32'd0);

    // Overflow coincident with ss in LAP.
    go(3'b001, S_RUN, "ovf_prep_run");
    go(3'b010, S_LAP, "ovf_prep_lap");
    wait_presc(3);
    drive(3'b001);
    ticks(6);
    check("ovf_en_align", 32'(cnt_en), 32'd1);
    ovf = 1'b1;
    tick();
    ovf = 1'b0;
    check("ovf_state", 32'(state), 32'(S_PAUSE));
    check("ovf_flag_set", 32'(ovf_flag), 32'd1);
    check("ovf_hold_clr", 32'(disp_hold), 32'd0);
    drive(3'b000);
    ticks(10);

    // Clear ignored in RUN, honoured in PAUSE.
    go(3'b001, S_RUN, "clr_prep_run");
    base = clr_seen;
    drive(3'b100);
    ticks(12);
    check("clr_run_ignored", 32'(state), 32'(S_RUN));
    drive(3'b000);
    ticks(10);
    check("clr_run_no_pulse", 32'(clr_seen - base), 32'd0);
    go(3'b001, S_PAUSE, "clr_prep_pause");
    check("flag_sticky", 32'(ovf_flag), 32'd1);
    base = clr_seen;
    drive(3'b100);
    wait_state(S_IDLE, n);
    check("clr_idle", 32'(state), 32'(S_IDLE));
    check("clr_pulse", 32'(cnt_clr), 32'd1);
    check("clr_flag", 32'(ovf_flag), 32'd0);
    tick();
    check("clr_pulse_end", 32'(cnt_clr), 32'd0);
    check("clr_presc", 32'(dut.presc), 32'd0);
    drive(3'b000);
    ticks(10);
    check("clr_once", 32'(clr_seen - base), 32'd1);

    // Asynchronous reset in LAP.
    go(3'b001, S_RUN, "rst_prep_run");
    go(3'b010, S_LAP, "rst_prep_lap");
    check("rst_prep_hold", 32'(disp_hold), 32'd1);
    #2;
    nrst = 1'b0;
    #1;
    check("rst_async", {24'd0, cnt_en, cnt_up, cnt_clr, lap_latch, disp_hold, ovf_flag, state}, 32'd0);
    tick();
    nrst = 1'b1;
    ticks(3);

    check("en_rules", 32'(viol), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
